// File: rtl/rv32i_stage_sequencer_pkg.sv
// Shared stage indices, opcode bit positions and FSM state encodings for the
// multi-cycle RV32I sequencer and its handshake timer.
package rv32i_stage_sequencer_pkg;

  localparam int STAGE_FETCH     = 0;
  localparam int STAGE_DECODE    = 1;
  localparam int STAGE_EXECUTE   = 2;
  localparam int STAGE_MEMORY    = 3;
  localparam int STAGE_WRITEBACK = 4;
  localparam int STAGE_WIDTH     = 5;

  // One-hot decoded opcode bit positions.
  localparam int OPCODE_LUI    = 0;
  localparam int OPCODE_AUIPC  = 1;
  localparam int OPCODE_JAL    = 2;
  localparam int OPCODE_JALR   = 3;
  localparam int OPCODE_BRANCH = 4;
  localparam int OPCODE_LOAD   = 5;
  localparam int OPCODE_STORE  = 6;
  localparam int OPCODE_OPIMM  = 7;
  localparam int OPCODE_OP     = 8;
  localparam int OPCODE_FENCE  = 9;
  localparam int OPCODE_SYSTEM = 10;
  localparam int OPCODE_WIDTH  = 11;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  function automatic logic is_onehot(input logic [OPCODE_WIDTH-1:0] op);
    return (op != '0) && ((op & (op - OPCODE_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/rv32i_handshake_timer.sv
// Shared request-wait counter for imem/dmem handshakes; o_expired flags the
// cycle in which the count would reach MEM_TIMEOUT.
module rv32i_handshake_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [15:0] LAST_COUNT = 16'(MEM_TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_count_en)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // An ack in the final wait cycle suppresses i_count_en, so the ack wins.
  assign o_expired = i_count_en && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/rv32i_stage_sequencer.sv
// One-instruction-at-a-time FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller
// with illegal-opcode and bus-timeout halt; ASRV32_INSTRET_EN enables o_instret.
module rv32i_stage_sequencer
  import rv32i_stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_stall,
  input  logic [OPCODE_WIDTH-1:0]  i_opcode,
  input  logic                     i_imem_ack,
  input  logic                     i_dmem_ack,
  output logic [STAGE_WIDTH-1:0]   o_stage,
  output logic                     o_imem_req,
  output logic                     o_dmem_req,
  output logic                     o_writeback_en,
  output logic                     o_retire,
  output logic                     o_illegal_instr,
  output logic                     o_bus_error,
  output logic [INSTRET_WIDTH-1:0] o_instret
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   mem_op, imem_req, dmem_req, wb_en;
  logic   timer_clear, timer_count, timer_expired;

  assign mem_op   = i_opcode[OPCODE_LOAD] | i_opcode[OPCODE_STORE];
  assign imem_req = (state_q == ST_FETCH) && !i_stall;
  assign dmem_req = (state_q == ST_MEMORY) && mem_op && !i_stall;
  assign wb_en    = (state_q == ST_WRITEBACK) && !i_stall;

  assign timer_count = (imem_req && !i_imem_ack) || (dmem_req && !i_dmem_ack);
  assign timer_clear = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEMORY));

  rv32i_handshake_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (timer_clear),
    .i_count_en (timer_count),
    .o_expired  (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if (!i_stall) begin
      case (state_q)
        ST_FETCH: begin
          if (i_imem_ack) begin
            state_d = ST_DECODE;
          end else if (timer_expired) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
          end
        end
        ST_DECODE: begin
          if (is_onehot(i_opcode)) begin
            state_d = ST_EXECUTE;
          end else begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        end
        ST_EXECUTE: state_d = ST_MEMORY;
        ST_MEMORY: begin
          if (!mem_op || i_dmem_ack) begin
            state_d = ST_WRITEBACK;
          end else if (timer_expired) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
          end
        end
        ST_WRITEBACK: state_d = ST_FETCH;
        default:      state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    o_stage = '0;
    if (!i_rst) begin
      case (state_q)
        ST_FETCH:     o_stage[STAGE_FETCH]     = 1'b1;
        ST_DECODE:    o_stage[STAGE_DECODE]    = 1'b1;
        ST_EXECUTE:   o_stage[STAGE_EXECUTE]   = 1'b1;
        ST_MEMORY:    o_stage[STAGE_MEMORY]    = 1'b1;
        ST_WRITEBACK: o_stage[STAGE_WRITEBACK] = 1'b1;
        default:      o_stage = '0;
      endcase
    end
  end

  assign o_imem_req      = imem_req && !i_rst;
  assign o_dmem_req      = dmem_req && !i_rst;
  assign o_writeback_en  = wb_en && !i_rst;
  assign o_retire        = wb_en && !i_rst;
  assign o_illegal_instr = illegal_q && !i_rst;
  assign o_bus_error     = bus_err_q && !i_rst;

`ifdef ASRV32_INSTRET_EN
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  assign instret_d = wb_en ? instret_q + INSTRET_WIDTH'(1) : instret_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      instret_q <= '0;
    else
      instret_q <= instret_d;
  end

  assign o_instret = i_rst ? '0 : instret_q;
`else
  assign o_instret = '0;
`endif

endmodule

// File: doc/rv32i_stage_sequencer.md
Name: rv32i_stage_sequencer

Overview:
Multi-cycle core controller that sequences the fetch/decode/execute/memory/writeback datapath one instruction at a time.
- Runs the imem and dmem request/ack handshakes.
- Asserts the writeback enable for exactly one cycle per instruction, which gates the PC/rd register update in the writeback stage.
- Detects illegal opcodes and memory timeouts; on either, parks the core in a halt state until reset.

Parameters:
MEM_TIMEOUT, 255, max cycles a request (imem or dmem) may wait for ack before bus error; range 1..65535
INSTRET_WIDTH, 64, width of retired-instruction counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_stall  in  1  external stall; freezes the FSM while high
i_opcode  in  `OPCODE_WIDTH  one-hot decoded opcode, valid from DECODE onward
i_imem_ack  in  1  instruction memory ack; meaningful only while o_imem_req=1
i_dmem_ack  in  1  data memory ack; meaningful only while o_dmem_req=1
o_stage  out  5  one-hot stage: [0]FETCH [1]DECODE [2]EXECUTE [3]MEMORY [4]WRITEBACK; all-zero in HALT
o_imem_req  out  1  instruction fetch request
o_dmem_req  out  1  load/store request
o_writeback_en  out  1  writeback stage enable
o_retire  out  1  one-cycle pulse when an instruction completes
o_illegal_instr  out  1  sticky; set on zero or multi-hot opcode
o_bus_error  out  1  sticky; set on handshake timeout
o_instret  out  INSTRET_WIDTH  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT (binary-encoded state register).
- Reset (synchronous, i_rst=1 at posedge):
  - state <= FETCH; timeout counter, sticky flags and o_instret <= 0.
  - While i_rst=1, all outputs are forced to 0, including o_stage.
- Output decode (combinational from state and i_stall):
  - o_imem_req = FETCH && !i_stall.
  - o_dmem_req = MEMORY && (load||store) && !i_stall.
  - o_writeback_en = WRITEBACK && !i_stall.
  - o_retire = o_writeback_en.
- Stall: with i_stall=1 the state, timeout counter and o_instret all hold; requests drop low and acks are ignored.
- FETCH: advance to DECODE on i_imem_ack while o_imem_req=1.
- DECODE: check i_opcode.
  - Zero or more than one bit set -> HALT; set o_illegal_instr.
  - Otherwise -> EXECUTE.
- EXECUTE: always advances to MEMORY after 1 cycle.
- MEMORY, load or store: hold o_dmem_req until i_dmem_ack, then go to WRITEBACK.
- MEMORY, any other opcode: advance to WRITEBACK after 1 cycle, with no request issued.
- WRITEBACK: after 1 cycle, return to FETCH and increment o_instret.
  - The counter wraps modulo 2^INSTRET_WIDTH.
  - Every opcode, including branch/store/system, retires; suppressing the rd write is the writeback stage's job.
- Latency: minimum 5 cycles per instruction, reached when both acks arrive in the first request cycle. A load with ack after k wait cycles takes 5+k cycles.
- Timeout counter:
  - Clears on entry to FETCH or MEMORY.
  - Increments each unstalled cycle in which a request is outstanding and no ack arrives.
  - When it reaches MEM_TIMEOUT: state -> HALT, o_bus_error=1.
  - If the ack arrives in the same cycle the count would reach MEM_TIMEOUT, the ack wins and the FSM advances normally.
- HALT: absorbing. All requests and enables are 0; sticky flags are held. Only i_rst exits.
- Reset mid-handshake: the request drops at once and the next instruction fetch starts fresh; a late ack arriving after reset is ignored.
- Acks seen outside their request window have no effect.

Optional Feature:
- Macro: ASRV32_INSTRET_EN.
- Defined: o_instret counter implemented as above.
- Undefined: o_instret tied to 0 and no counter flops are inferred; o_retire is unaffected.

Decomposition:
- Shared header asrv32_header.vh holds:
  - stage-index defines: STAGE_FETCH..STAGE_WRITEBACK, STAGE_WIDTH=5;
  - FSM state encodings, including HALT;
  - existing OPCODE_* bit indices and OPCODE_WIDTH.
- One natural sub-module: rv32i_handshake_timer. It is the shared timeout counter (clear, count-enable, expired), reused for both the imem and dmem waits.

Test Plan:
- Reset, then ack every request immediately, ALU opcode x3:
  - o_stage cycles 1,2,4,8,16 every 5 cycles;
  - o_writeback_en high 1 cycle each;
  - o_instret=3.
- Load opcode, i_dmem_ack asserted 4 cycles after o_dmem_req rises: MEMORY lasts 5 cycles, instruction completes in 9 cycles, o_retire pulses once.
- i_stall=1 for 3 cycles during EXECUTE, with i_dmem_ack toggling: state is frozen, o_dmem_req=0, the spurious acks are ignored, and completion is delayed exactly 3 cycles.
- i_opcode=0 at DECODE, then separately a 2-hot opcode: HALT, o_stage=0, o_illegal_instr=1, and no further o_imem_req until i_rst.
- MEM_TIMEOUT=8, imem never acks:
  - after 8 request cycles, HALT with o_bus_error=1;
  - repeat with ack on the 8th request cycle -> normal DECODE, no error.
- Assert i_rst for 1 cycle while in MEMORY with o_dmem_req=1:
  - next cycle is FETCH, o_instret=0, flags clear;
  - with ASRV32_INSTRET_EN undefined, o_instret stays 0 throughout.
